sn7493_chain_ctrl: RTL

- Single-clock sequencer that replaces a TTL ripple-counter chain (7493-style stages plus terminal-count decode) with one synchronous, clock-enabled count.
- Samples an external falling-edge count clock and the R0/R1 reset pair, keeps the modelled count, and issues per-bit toggle strobes and a wrap pulse.
- Sits between slow TTL-domain signals and the FPGA system clock. Used for the horizontal/vertical video counters (e.g. modulus 455).

---
 rtl/sn7493_chain_ctrl_pkg.sv | 16 +
 rtl/sn7493_chain_ctrl_if.sv | 24 ++
 rtl/sn7493_chain_ctrl_edge_sync.sv | 38 +++
 rtl/sn7493_chain_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/sn7493_chain_ctrl_pkg.sv
// rtl/sn7493_chain_ctrl_pkg.sv - shared types, constants and count helper for the 7493 chain replacement
package sn7493_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_CLEAR
  } state_e;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic int unsigned next_count(input int unsigned q, input int unsigned modulus);
    return (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
  endfunction

endpackage

// File: rtl/sn7493_chain_ctrl_if.sv
// rtl/sn7493_chain_ctrl_if.sv - TTL-side inputs and count outputs of the chain controller
interface sn7493_chain_ctrl_if #(
  parameter int WIDTH = 9
);
  logic             CKA_N;
  logic             R0;
  logic             R1;
  logic             RUN;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] STAGE_CE;
  logic             TC;
  logic             CLR;
  logic             OVERRUN;

  modport master (
    output CKA_N, R0, R1, RUN,
    input  Q, STAGE_CE, TC, CLR, OVERRUN
  );

  modport slave (
    input  CKA_N, R0, R1, RUN,
    output Q, STAGE_CE, TC, CLR, OVERRUN
  );
endinterface

// File: rtl/sn7493_chain_ctrl_edge_sync.sv
// rtl/sn7493_chain_ctrl_edge_sync.sv - multi-flop synchronizer with falling-edge detect on the edge lane
module edge_sync #(
  parameter int   STAGES   = 2,
  parameter int   LVL_W    = 2,
  parameter logic EDGE_RST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             edge_i,
  input  logic [LVL_W-1:0] lvl_i,
  output logic [LVL_W-1:0] lvl_o,
  output logic             fall_o
);
  localparam int W = LVL_W + 1;
  localparam logic [W-1:0] RST_VEC = {{LVL_W{1'b0}}, EDGE_RST};

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [STAGES-1:0]        vld_q;
  logic                     prev_q;

  // vld_q marks which stages hold real samples rather than reset values, so a
  // count clock held low across reset release is not mistaken for a fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VEC}};
      vld_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], {lvl_i, edge_i}};
      vld_q  <= {vld_q[STAGES-2:0], 1'b1};
      prev_q <= sync_q[STAGES-1][0] & vld_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1][W-1:1];
  assign fall_o = prev_q & ~sync_q[STAGES-1][0];

endmodule

// File: rtl/sn7493_chain_ctrl.sv
// rtl/sn7493_chain_ctrl.sv - synchronous replacement for a 7493 ripple chain with terminal-count decode
module sn7493_chain_ctrl
  import sn7493_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int MODULUS     = 455,
  parameter int SYNC_STAGES = 2
) (
  input logic              CLK,
  input logic              RESET_N,
  sn7493_chain_ctrl_if.slave bus
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("sn7493_chain_ctrl: MODULUS out of range 2..2**WIDTH");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("sn7493_chain_ctrl: SYNC_STAGES below minimum");
  end

  logic [1:0] rst_pair_w;
  logic       fall_w;
  logic       clr_req;

  edge_sync #(
    .STAGES  (SYNC_STAGES),
    .LVL_W   (2),
    .EDGE_RST(1'b1)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RESET_N),
    .edge_i(bus.CKA_N),
    .lvl_i ({bus.R1, bus.R0}),
    .lvl_o (rst_pair_w),
    .fall_o(fall_w)
  );

  assign clr_req = &rst_pair_w;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] ce_q;
  logic             tc_q;
  logic             clr_q;
  logic             ovr_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_d;

  always_comb begin
    q_d    = WIDTH'(next_count(32'(q_q), unsigned'(MODULUS)));
    wrap_d = (q_d == '0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      ce_q    <= '0;
      tc_q    <= 1'b0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ce_q <= '0;
      tc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q <= ST_CLEAR;
            clr_q   <= 1'b1;
            q_q     <= '0;
            ce_q    <= q_q;
          end else if (bus.RUN) begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // A clear request beats a count edge arriving in the same cycle.
          if (clr_req) begin
            state_q <= ST_CLEAR;
            clr_q   <= 1'b1;
            q_q     <= '0;
            ce_q    <= q_q;
          end else begin
            if (fall_w) begin
              q_q  <= q_d;
              ce_q <= q_q ^ q_d;
              tc_q <= wrap_d;
            end
            if (!bus.RUN) state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (fall_w) ovr_q <= 1'b1;
          if (!clr_req) begin
            clr_q   <= 1'b0;
            state_q <= bus.RUN ? ST_COUNT : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Q        = q_q;
  assign bus.STAGE_CE = ce_q;
  assign bus.TC       = tc_q;
  assign bus.CLR      = clr_q;
  assign bus.OVERRUN  = ovr_q;

endmodule
